// File: rtl/control_pkg.sv
// Shared types for the VeriRISC sequencing controller: opcode and phase encodings.
package control_pkg;

    typedef enum logic [2:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_t;

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } states_t;

    // Opcodes whose execute phases read an operand from memory into the accumulator.
    function automatic logic is_aluop(opcode_t op);
        return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    endfunction

endpackage

// File: rtl/control.sv
// VeriRISC sequencer: free-running eight-phase counter with a combinational strobe decoder.
//
// state      | meaning
// INST_ADDR  | instruction address on the bus, no strobes
// INST_FETCH | read instruction from memory
// INST_LOAD  | latch instruction into IR
// IDLE       | hold IR load while the bus settles
// OP_ADDR    | bump PC past the instruction, flag HLT
// OP_FETCH   | read operand for ALU-class opcodes
// ALU_OP     | load accumulator, SKZ skip, JMP target load
// STORE      | finish ALU load, STO write, JMP PC update
module control
    import control_pkg::*;
(
    input  logic    clk,
    input  logic    rst_,
    input  opcode_t opcode,
    input  logic    zero,
    output logic    mem_rd,
    output logic    load_ir,
    output logic    halt,
    output logic    inc_pc,
    output logic    load_ac,
    output logic    load_pc,
    output logic    mem_wr
);

    states_t lstate;
    logic    aluop;

    // Sequencing ignores opcode and zero; STORE wraps naturally to INST_ADDR.
    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            lstate <= INST_ADDR;
        end else begin
            lstate <= states_t'(lstate + 3'd1);
        end
    end

    assign aluop = is_aluop(opcode);

    always_comb begin
        mem_rd  = 1'b0;
        load_ir = 1'b0;
        halt    = 1'b0;
        inc_pc  = 1'b0;
        load_ac = 1'b0;
        load_pc = 1'b0;
        mem_wr  = 1'b0;
        case (lstate)
            INST_ADDR: ;
            INST_FETCH: begin
                mem_rd = 1'b1;
            end
            INST_LOAD, IDLE: begin
                mem_rd  = 1'b1;
                load_ir = 1'b1;
            end
            OP_ADDR: begin
                inc_pc = 1'b1;
                halt   = (opcode == HLT);
            end
            OP_FETCH: begin
                mem_rd = aluop;
            end
            ALU_OP: begin
                mem_rd  = aluop;
                load_ac = aluop;
                inc_pc  = (opcode == SKZ) && zero;
                load_pc = (opcode == JMP);
            end
            STORE: begin
                mem_rd  = aluop;
                load_ac = aluop;
                inc_pc  = (opcode == JMP);
                load_pc = (opcode == JMP);
                mem_wr  = (opcode == STO);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control.sv
// Self-checking bench for the VeriRISC sequencer against a phase/opcode rule model.
module tb_control;
    import control_pkg::*;

    logic    clk = 1'b0;
    logic    rst_ = 1'b1;
    opcode_t opcode = HLT;
    logic    zero = 1'b0;
    logic    mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr;

    int n_checks = 0;
    int n_fail   = 0;

    control dut (
        .clk     (clk),
        .rst_    (rst_),
        .opcode  (opcode),
        .zero    (zero),
        .mem_rd  (mem_rd),
        .load_ir (load_ir),
        .halt    (halt),
        .inc_pc  (inc_pc),
        .load_ac (load_ac),
        .load_pc (load_pc),
        .mem_wr  (mem_wr)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] dut_vec();
        return {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr};
    endfunction

    // Expected strobes from the phase number (0..7) and instruction fields.
    function automatic logic [6:0] exp_vec(int p, int op, logic z);
        bit alu, e_rd, e_ir, e_hlt, e_inc, e_ac, e_pc, e_wr;
        alu   = (op >= 2) && (op <= 5);
        e_rd  = (p >= 1 && p <= 3) || (p >= 5 && alu);
        e_ir  = (p == 2) || (p == 3);
        e_hlt = (p == 4) && (op == 0);
        e_inc = (p == 4) || (p == 6 && op == 1 && z) || (p == 7 && op == 7);
        e_ac  = (p >= 6) && alu;
        e_pc  = (p >= 6) && (op == 7);
        e_wr  = (p == 7) && (op == 6);
        return {e_rd, e_ir, e_hlt, e_inc, e_ac, e_pc, e_wr};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Entered just after a rising edge with the DUT at phase 0; returns likewise
    // unless aborted, in which case it returns mid-cycle with reset released.
    task automatic run_instr(input int op, input logic z, input int abort_at, output bit aborted);
        aborted = 1'b0;
        opcode  = opcode_t'(op[2:0]);
        zero    = z;
        for (int p = 0; p < 8; p++) begin
            #1;
            check_eq($sformatf("phase op%0d z%0d p%0d", op, z, p), 32'(dut.lstate), 32'(p));
            check_eq($sformatf("vec op%0d z%0d p%0d", op, z, p), 32'(dut_vec()), 32'(exp_vec(p, op, z)));
            if (p == abort_at) begin
                rst_ = 1'b1;
                #1;
                check_eq("abort phase", 32'(dut.lstate), 32'(0));
                check_eq("abort vec", 32'(dut_vec()), 32'(0));
                @(negedge clk);
                rst_ = 1'b0;
                aborted = 1'b1;
                return;
            end
            @(posedge clk);
        end
    endtask

    initial begin
        bit ab;
        int op;
        logic z;

        rst_ = 1'b1;
        opcode = HLT;
        zero = 1'b0;
        #2;
        check_eq("reset async phase", 32'(dut.lstate), 32'(0));
        check_eq("reset async vec", 32'(dut_vec()), 32'(0));
        @(posedge clk);
        #1;
        check_eq("reset held phase", 32'(dut.lstate), 32'(0));
        @(negedge clk);
        rst_ = 1'b0;
        #1;
        // Still in INST_ADDR until the next edge; run the first instruction from here.
        run_instr(0, 1'b0, -1, ab);
        #1;

        for (int i = 0; i < 16; i++) begin
            run_instr(i % 8, (i >= 8), (i == 9) ? 3 : -1, ab);
            if (ab) begin
                run_instr(i % 8, (i >= 8), -1, ab);
            end
        end

        for (int k = 0; k < 40; k++) begin
            op = int'($urandom_range(0, 7));
            z  = 1'($urandom_range(0, 1));
            run_instr(op, z, (k == 20) ? int'($urandom_range(0, 7)) : -1, ab);
            if (ab) begin
                run_instr(op, z, -1, ab);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit, got running expected done");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
